// File: rtl/m2764a_prog_seq.sv
// m2764a_prog_seq
// Programs a single byte of a 2764A-class EPROM using the interactive
// algorithm: repeated 1 ms programming pulses, each followed by a read-back
// verify. Once the byte reads back correctly, an overprogram pulse of
// OVP_MULT ms per pulse already used is applied. If the byte never verifies,
// the sequence gives up after MAX_TRIES pulses and raises a sticky fail flag.
//
// Ports
//   osc        24 MHz clock (single domain)
//   rst        synchronous active-high reset
//   cmd_start  one-cycle request to program one byte (accepted in IDLE only)
//   cmd_addr   target byte address
//   cmd_data   byte value to program
//   busy       sequence in progress (low in IDLE only)
//   done       one-cycle completion pulse
//   fail       sticky: last sequence used up MAX_TRIES without verifying
//   tries      pulses applied in the current or last sequence
//   dut_addr   EPROM A12..A0
//   dut_dout   data driven onto Q7..Q0 while dut_doe=1
//   dut_doe    1 = drive dut_dout onto the Q pins
//   dut_E      chip enable, active low
//   dut_G      output enable, active low
//   dut_P      program strobe, active low
//   dut_q      Q7..Q0 as sampled from the ZIF socket
//
// Every socket-facing output is a register, decoded from the next state, so
// all control pins change together on one clock edge. This keeps the
// bus-contention rules free of glitches: P is never low while G is low or
// while the bench is not driving Q, and Q is never driven while G is low.

module m2764a_prog_seq #(
  parameter int TICKS_PER_MS = 24000,
  parameter int SETTLE_CYC   = 24,
  parameter int MAX_TRIES    = 25,
  parameter int OVP_MULT     = 3
) (
  input  logic        osc,
  input  logic        rst,
  input  logic        cmd_start,
  input  logic [12:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        busy,
  output logic        done,
  output logic        fail,
  output logic [4:0]  tries,
  output logic [12:0] dut_addr,
  output logic [7:0]  dut_dout,
  output logic        dut_doe,
  output logic        dut_E,
  output logic        dut_G,
  output logic        dut_P,
  input  logic [7:0]  dut_q
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    PULSE   = 3'd2,
    HOLD    = 3'd3,
    VERIFY  = 3'd4,
    OVSETUP = 3'd5,
    OVP     = 3'd6,
    FIN     = 3'd7
  } state_t;

  // The shared down-counter has to cover the longest overprogram pulse
  // (OVP_MULT * MAX_TRIES ms) as well as the settle and pulse phases.
  localparam int OVP_MAX_CYC = OVP_MULT * MAX_TRIES * TICKS_PER_MS;
  localparam int CNT_MAX_A   = (OVP_MAX_CYC > TICKS_PER_MS) ? OVP_MAX_CYC : TICKS_PER_MS;
  localparam int CNT_MAX     = (CNT_MAX_A > SETTLE_CYC) ? CNT_MAX_A : SETTLE_CYC;
  localparam int CNT_W       = $clog2(CNT_MAX + 1);

  // A phase that lasts N cycles is loaded with N-1 and exits when the count is 0.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(TICKS_PER_MS - 1);
  localparam logic [CNT_W-1:0] OVP_STEP    = CNT_W'(OVP_MULT * TICKS_PER_MS);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [4:0]       MAX_TRIES_V = 5'(MAX_TRIES);

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [CNT_W-1:0]  ovp_len_s;
  logic              cnt_zero_s;
  logic [4:0]        tries_r, tries_s;
  logic              fail_r, fail_s;
  logic [12:0]       addr_r, addr_s;
  logic [7:0]        data_r, data_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic              doe_r, doe_s;
  logic              e_r, e_s;
  logic              g_r, g_s;
  logic              p_r, p_s;

  assign cnt_zero_s = (cnt_r == {CNT_W{1'b0}});
  // tries_r is at least 1 here because OVP is only reached after a pulse.
  assign ovp_len_s  = CNT_W'(tries_r) * OVP_STEP;

  // Next-state, counter, datapath and registered-output decode.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    tries_s = tries_r;
    fail_s  = fail_r;
    addr_s  = addr_r;
    data_s  = data_r;

    case (state_r)
      IDLE: begin
        if (cmd_start) begin
          addr_s  = cmd_addr;
          data_s  = cmd_data;
          tries_s = 5'd0;
          fail_s  = 1'b0;
          // An erased location already reads 8'hFF: nothing to program.
          if (cmd_data == 8'hFF) begin
            state_s = FIN;
          end else begin
            state_s = SETUP;
            cnt_s   = SETTLE_LOAD;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (cnt_zero_s) begin
          state_s = PULSE;
          cnt_s   = PULSE_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_zero_s) begin
          state_s = HOLD;
          cnt_s   = SETTLE_LOAD;
          tries_s = tries_r + 5'd1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_zero_s) begin
          state_s = VERIFY;
          cnt_s   = SETTLE_LOAD;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      VERIFY: begin
        // Q is only trusted on the last cycle, after the output has settled.
        if (cnt_zero_s) begin
          if (dut_q == data_r) begin
            state_s = OVSETUP;
            cnt_s   = SETTLE_LOAD;
          end else if (tries_r < MAX_TRIES_V) begin
            state_s = SETUP;
            cnt_s   = SETTLE_LOAD;
          end else begin
            fail_s  = 1'b1;
            state_s = FIN;
          end
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      OVSETUP: begin
        if (cnt_zero_s) begin
          state_s = OVP;
          cnt_s   = ovp_len_s - CNT_ONE;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      OVP: begin
        if (cnt_zero_s) begin
          state_s = FIN;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Socket pins for the state being entered; safe idle levels by default.
    busy_s = (state_s != IDLE);
    done_s = (state_s == FIN);
    e_s    = 1'b1;
    g_s    = 1'b1;
    p_s    = 1'b1;
    doe_s  = 1'b0;
    case (state_s)
      SETUP, HOLD, OVSETUP: begin
        e_s   = 1'b0;
        doe_s = 1'b1;
      end
      PULSE, OVP: begin
        e_s   = 1'b0;
        doe_s = 1'b1;
        p_s   = 1'b0;
      end
      VERIFY: begin
        e_s = 1'b0;
        g_s = 1'b0;
      end
      IDLE, FIN: begin
        e_s = 1'b1;
      end
      default: begin
        e_s = 1'b1;
      end
    endcase
  end

  // State, counter, latched command and output registers with synchronous reset.
  always_ff @(posedge osc) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      tries_r <= 5'd0;
      fail_r  <= 1'b0;
      addr_r  <= 13'd0;
      data_r  <= 8'd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      doe_r   <= 1'b0;
      e_r     <= 1'b1;
      g_r     <= 1'b1;
      p_r     <= 1'b1;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      tries_r <= tries_s;
      fail_r  <= fail_s;
      addr_r  <= addr_s;
      data_r  <= data_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      doe_r   <= doe_s;
      e_r     <= e_s;
      g_r     <= g_s;
      p_r     <= p_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign fail     = fail_r;
  assign tries    = tries_r;
  assign dut_addr = addr_r;
  assign dut_dout = data_r;
  assign dut_doe  = doe_r;
  assign dut_E    = e_r;
  assign dut_G    = g_r;
  assign dut_P    = p_r;

endmodule

// File: tb/tb_m2764a_prog_seq.sv
// Testbench for m2764a_prog_seq with short timing parameters.
// Stimulus pushes the expected outcome of each program command into a
// scoreboard queue; an independent monitor on the falling clock edge tracks
// busy length, P-low runs and cycles, and pops/compares on every done pulse.
// The monitor also checks pin invariants, reset values, held address/data,
// and persistence of tries/fail while idle.

module tb_m2764a_prog_seq;

  localparam int TPM    = 4;
  localparam int SETTLE = 2;
  localparam int MAXT   = 3;
  localparam int MULT   = 3;

  logic        osc;
  logic        rst;
  logic        cmd_start;
  logic [12:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        busy, done, fail;
  logic [4:0]  tries;
  logic [12:0] dut_addr;
  logic [7:0]  dut_dout;
  logic        dut_doe, dut_E, dut_G, dut_P;
  logic [7:0]  dut_q;

  m2764a_prog_seq #(
    .TICKS_PER_MS(TPM),
    .SETTLE_CYC  (SETTLE),
    .MAX_TRIES   (MAXT),
    .OVP_MULT    (MULT)
  ) dut (
    .osc      (osc),
    .rst      (rst),
    .cmd_start(cmd_start),
    .cmd_addr (cmd_addr),
    .cmd_data (cmd_data),
    .busy     (busy),
    .done     (done),
    .fail     (fail),
    .tries    (tries),
    .dut_addr (dut_addr),
    .dut_dout (dut_dout),
    .dut_doe  (dut_doe),
    .dut_E    (dut_E),
    .dut_G    (dut_G),
    .dut_P    (dut_P),
    .dut_q    (dut_q)
  );

  initial osc = 1'b0;
  always #5 osc = ~osc;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
    int          busy_cyc;
    int          p_runs;
    int          p_low;
    int          tries;
    int          fail;
  } exp_t;

  exp_t sb_q[$];

  // Monitor-owned state.
  int n_cmp  = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  int run_cnt  = 0;
  int plow_cnt = 0;
  int last_tries = 0;
  int last_fail  = 0;
  logic p_prev   = 1'b1;
  logic rst_pend = 1'b0;
  logic armed    = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: samples away from the active edge.
  always @(negedge osc) begin
    exp_t e;
    if (rst_pend) begin
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_tries", int'(tries), 0);
      chk("rst_addr", int'(dut_addr), 0);
      chk("rst_dout", int'(dut_dout), 0);
      chk("rst_doe", int'(dut_doe), 0);
      chk("rst_E", int'(dut_E), 1);
      chk("rst_G", int'(dut_G), 1);
      chk("rst_P", int'(dut_P), 1);
      busy_cnt   = 0;
      run_cnt    = 0;
      plow_cnt   = 0;
      last_tries = 0;
      last_fail  = 0;
      armed      = 1'b1;
    end else if (armed) begin
      chk("inv_P_with_G_or_doe", int'(!dut_P && (!dut_G || !dut_doe)), 0);
      chk("inv_doe_with_G", int'(dut_doe && !dut_G), 0);
      if (busy) busy_cnt++;
      if (!dut_P) plow_cnt++;
      if (!dut_P && p_prev) run_cnt++;
      if (busy && sb_q.size() > 0) begin
        chk("held_addr", int'(dut_addr), int'(sb_q[0].addr));
        chk("held_dout", int'(dut_dout), int'(sb_q[0].data));
      end
      if (!busy) begin
        chk("idle_tries", int'(tries), last_tries);
        chk("idle_fail", int'(fail), last_fail);
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("spurious_done", int'(done), 0);
        end else begin
          e = sb_q.pop_front();
          chk("busy_cycles", busy_cnt, e.busy_cyc);
          chk("p_runs", run_cnt, e.p_runs);
          chk("p_low_cycles", plow_cnt, e.p_low);
          chk("tries", int'(tries), e.tries);
          chk("fail", int'(fail), e.fail);
          chk("done_addr", int'(dut_addr), int'(e.addr));
          last_tries = e.tries;
          last_fail  = e.fail;
        end
        busy_cnt = 0;
        run_cnt  = 0;
        plow_cnt = 0;
      end
    end
    p_prev   = dut_P;
    rst_pend = rst;
  end

  task automatic push_exp(input logic [12:0] a, input logic [7:0] d, input int b,
                          input int r, input int pl, input int t, input int f);
    exp_t e;
    e.addr = a; e.data = d; e.busy_cyc = b; e.p_runs = r; e.p_low = pl;
    e.tries = t; e.fail = f;
    sb_q.push_back(e);
  endtask

  task automatic issue(input logic [12:0] a, input logic [7:0] d);
    @(posedge osc); #1;
    cmd_start = 1'b1; cmd_addr = a; cmd_data = d;
    @(posedge osc); #1;
    cmd_start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge osc); #1;
    end
  endtask

  task automatic wait_done(input string what);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge osc); #1;
    end
    if (!got) begin
      $display("FAIL timeout_%s: got no done, expected done within 300 cycles", what);
      $fatal(1);
    end
  endtask

  task automatic wait_pin(input string what, input bit want_g, input bit lvl);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ((want_g ? dut_G : dut_P) == lvl) begin
        got = 1'b1;
        break;
      end
      @(posedge osc); #1;
    end
    if (!got) begin
      $display("FAIL timeout_%s: pin never reached %0d", what, lvl);
      $fatal(1);
    end
  endtask

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_addr = 13'd0; cmd_data = 8'd0; dut_q = 8'hFF;
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(3);

    // 1: verifies first time; 4-cycle pulse + 12-cycle OVP; busy 25. A
    //    cmd_start mid-sequence must be ignored.
    dut_q = 8'h5A;
    push_exp(13'h1ABC, 8'h5A, 25, 2, 16, 1, 0);
    issue(13'h1ABC, 8'h5A);
    idle_cycles(4);
    cmd_start = 1'b1; cmd_addr = 13'h0123; cmd_data = 8'h77;
    @(posedge osc); #1;
    cmd_start = 1'b0;
    wait_done("s1");
    idle_cycles(4);

    // 2: first verify mismatches, second matches; OVP 3*2*4 = 24 cycles.
    dut_q = 8'h00;
    push_exp(13'h0A55, 8'h3C, 47, 3, 32, 2, 0);
    issue(13'h0A55, 8'h3C);
    wait_pin("s2_g_low", 1'b1, 1'b0);
    wait_pin("s2_g_high", 1'b1, 1'b1);
    dut_q = 8'h3C;
    wait_done("s2");
    idle_cycles(4);

    // 3: Q stuck at FF; three pulses, no OVP, fail.
    dut_q = 8'hFF;
    push_exp(13'h1FFF, 8'h00, 31, 3, 12, 3, 1);
    issue(13'h1FFF, 8'h00);
    wait_done("s3");
    idle_cycles(5);

    // 4: data FF goes straight to FIN; tries and fail are cleared.
    push_exp(13'h0FFF, 8'hFF, 1, 0, 0, 0, 0);
    issue(13'h0FFF, 8'hFF);
    wait_done("s4");
    idle_cycles(4);

    // 5: reset together with cmd_start wins.
    @(posedge osc); #1;
    rst = 1'b1; cmd_start = 1'b1; cmd_addr = 13'h1555; cmd_data = 8'h01;
    @(posedge osc); #1;
    rst = 1'b0; cmd_start = 1'b0;
    idle_cycles(4);

    // 6: reset during the second PULSE cycle.
    dut_q = 8'h11;
    issue(13'h0042, 8'h11);
    wait_pin("s6_p_low", 1'b0, 1'b0);
    @(posedge osc); #1;
    rst = 1'b1;
    @(posedge osc); #1;
    rst = 1'b0;
    idle_cycles(6);

    if (sb_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb_q.size());
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
